// File: rtl/conv_out_packer_pkg.sv
// Shared numeric formats for the convolution output path: INT8/INT16 widths,
// saturation limits and the signed types built from them.
package conv_out_packer_pkg;
    localparam int INT8_W    = 8;
    localparam int INT16_W   = 16;
    localparam int SUM_W     = INT16_W + 1;
    localparam int BYTES_W   = 4;
    localparam int INT8_MAX  = (2 ** (INT8_W - 1)) - 1;
    localparam int INT8_MIN  = -(2 ** (INT8_W - 1));
    localparam int INT16_MAX = (2 ** (INT16_W - 1)) - 1;
    localparam int INT16_MIN = -(2 ** (INT16_W - 1));

    typedef logic signed [INT8_W-1:0]  int8_t;
    typedef logic signed [INT16_W-1:0] int16_t;
    typedef logic signed [SUM_W-1:0]   sum17_t;
endpackage

// File: rtl/out_word_fifo.sv
// Word FIFO for packed results; read data reads as zero while empty.
module out_word_fifo
#(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/conv_out_packer.sv
// Requantises INT16 adder-tree sums to INT8 (bias, ReLU, rounded shift) and
// packs PACK results per output word, with flush for partial words.
module conv_out_packer
    import conv_out_packer_pkg::*;
#(
    parameter int PACK  = 4,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [INT16_W-1:0] res_conv,
    input  logic signed [INT16_W-1:0] bias,
    input  logic [3:0]                shift,
    input  logic                      relu_en,
    input  logic                      flush,
    output logic [PACK*INT8_W-1:0]    out_data,
    output logic [BYTES_W-1:0]        out_bytes,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = PACK * INT8_W + BYTES_W;
    localparam logic [BYTES_W-1:0] PACK_M1 = BYTES_W'(PACK - 1);

    function automatic int16_t sat16(input sum17_t x);
        if (x > sum17_t'(INT16_MAX)) return int16_t'(INT16_MAX);
        if (x < sum17_t'(INT16_MIN)) return int16_t'(INT16_MIN);
        return int16_t'(x);
    endfunction

    function automatic int8_t sat8(input sum17_t x);
        if (x > sum17_t'(INT8_MAX)) return int8_t'(INT8_MAX);
        if (x < sum17_t'(INT8_MIN)) return int8_t'(INT8_MIN);
        return int8_t'(x);
    endfunction

    function automatic int8_t requant(input int16_t s, input logic [3:0] sh, input logic relu);
        sum17_t rnd;
        sum17_t t;
        if (relu && s < 0) return '0;
        rnd = (sh == 4'd0) ? '0 : (sum17_t'(1) <<< (sh - 4'd1));
        t   = (sum17_t'(s) + rnd) >>> sh;
        return sat8(t);
    endfunction

    logic                      vld_p1, vld_p2;
    int16_t                    sum_p1;
    int8_t                     byte_p2;
    logic [BYTES_W-1:0]        byte_cnt;
    logic [PACK*INT8_W-1:0]    pack_q, word_next;
    logic                      flush_pend, flush_fire, part_push, word_done;
    logic                      accept, fifo_push, fifo_full, fifo_empty;
    logic [BYTES_W-1:0]        push_bytes;
    logic [FW-1:0]             pop_data;
    logic [CW-1:0]             fifo_count;

    assign in_ready   = reset && !flush_pend && (fifo_count <= CW'(DEPTH - 3));
    assign accept     = in_valid && in_ready;
    assign word_done  = vld_p2 && (byte_cnt == PACK_M1);
    assign flush_fire = flush_pend && !vld_p1 && !vld_p2 && (byte_cnt == '0 || !fifo_full);
    assign part_push  = flush_fire && (byte_cnt != '0);
    assign fifo_push  = word_done || part_push;
    assign push_bytes = word_done ? BYTES_W'(PACK) : byte_cnt;

    // Slots at or above the counter are rebuilt from zero, so stale bytes never leak.
    always_comb begin
        word_next = '0;
        for (int i = 0; i < PACK; i++) begin
            if (BYTES_W'(i) < byte_cnt)
                word_next[i*INT8_W +: INT8_W] = pack_q[i*INT8_W +: INT8_W];
            else if (BYTES_W'(i) == byte_cnt && vld_p2)
                word_next[i*INT8_W +: INT8_W] = byte_p2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            byte_cnt   <= '0;
            flush_pend <= 1'b0;
        end else begin
            vld_p1     <= accept;
            vld_p2     <= vld_p1;
            flush_pend <= (flush_pend && !flush_fire) || flush;
            if (word_done || part_push) byte_cnt <= '0;
            else if (vld_p2)            byte_cnt <= byte_cnt + BYTES_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // p1: bias add with INT16 saturation
        if (accept) sum_p1 <= sat16(sum17_t'(res_conv) + sum17_t'(bias));
        // p2: ReLU, rounded shift, INT8 saturation
        if (vld_p1) byte_p2 <= requant(sum_p1, shift, relu_en);
        // pack: byte placed into the word under construction
        if (vld_p2) pack_q <= word_next;
    end

    out_word_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({push_bytes, word_next}),
        .pop       (out_ready),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_bytes = pop_data[FW-1 -: BYTES_W];
    assign out_data  = pop_data[PACK*INT8_W-1:0];
endmodule

// File: tb/tb_conv_out_packer.sv
// Directed bench for conv_out_packer: a PACK=4 instance for packing, rounding,
// flush and reset, plus a PACK=1 instance for FIFO back-pressure.
module tb_conv_out_packer;
    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid, flush, relu_en, out_ready;
    logic signed [15:0] res_conv, bias;
    logic [3:0]         shift;
    logic               in_ready, out_valid;
    logic [31:0]        out_data;
    logic [3:0]         out_bytes;
    logic               b_in_valid, b_flush, b_out_ready;
    logic               b_in_ready, b_out_valid;
    logic [7:0]         b_out_data;
    logic [3:0]         b_out_bytes;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_out_packer #(.PACK(4), .DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .res_conv(res_conv), .bias(bias), .shift(shift), .relu_en(relu_en),
        .flush(flush), .out_data(out_data), .out_bytes(out_bytes),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    conv_out_packer #(.PACK(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .res_conv(res_conv), .bias(bias), .shift(shift), .relu_en(relu_en),
        .flush(b_flush), .out_data(b_out_data), .out_bytes(b_out_bytes),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int val, input logic fl);
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        res_conv = 16'(val);
        in_valid = 1'b1;
        flush    = fl;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        step();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk(tag, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   nxt;
        int   accepted;
        int   drop_at;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
        res_conv = '0; bias = '0; shift = '0;
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_bytes", {60'd0, out_bytes}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        step();

        // Four 100+28 results, shift 2 -> 0x20 each, word 3 cycles after last transfer
        res_conv = 16'sd100; bias = 16'sd28; shift = 4'd2; relu_en = 1'b0;
        in_valid = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        step();
        chk("lat_early", {63'd0, out_valid}, 64'd0);
        step();
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("w1_data", {32'd0, out_data}, 64'h20202020);
        chk("w1_bytes", {60'd0, out_bytes}, 64'd4);
        step();
        chk("w1_popped", {63'd0, out_valid}, 64'd0);

        // Saturation and ReLU: 0x7F, 0x00, 0x80, 0x01
        out_ready = 1'b0; shift = 4'd0;
        bias = 16'sd1;  relu_en = 1'b0; send(32767, 1'b0);
        bias = 16'sd0;  relu_en = 1'b1; send(-300, 1'b0);
        relu_en = 1'b0; send(-300, 1'b0);
        send(1, 1'b0);
        wait_valid("w2_valid");
        chk("w2_data", {32'd0, out_data}, 64'h0180007F);
        chk("w2_bytes", {60'd0, out_bytes}, 64'd4);
        step(); step();
        chk("w2_hold_data", {32'd0, out_data}, 64'h0180007F);
        chk("w2_hold_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("w2_popped", {63'd0, out_valid}, 64'd0);

        // Rounding 6->2, 5->1, -6->-1, then flushed as a 3-byte word
        shift = 4'd2;
        send(6, 1'b0); send(5, 1'b0); send(-6, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl1_in_ready", {63'd0, in_ready}, 64'd0);
        wait_valid("fl1_valid");
        chk("fl1_data", {32'd0, out_data}, 64'h00FF0102);
        chk("fl1_bytes", {60'd0, out_bytes}, 64'd3);
        step();

        // 0xAA, 0xBB, then 0xCC with a coincident flush
        shift = 4'd0;
        send(-86, 1'b0); send(-69, 1'b0); send(-52, 1'b1);
        chk("fl2_in_ready_low", {63'd0, in_ready}, 64'd0);
        wait_valid("fl2_valid");
        chk("fl2_data", {32'd0, out_data}, 64'h00CCBBAA);
        chk("fl2_bytes", {60'd0, out_bytes}, 64'd3);
        chk("fl2_in_ready_back", {63'd0, in_ready}, 64'd1);
        step();
        chk("fl2_popped", {63'd0, out_valid}, 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_quiet("fl_empty_noword", 6);

        // PACK=1 instance: back-pressure stores exactly DEPTH words
        b_out_ready = 1'b0; nxt = 1; accepted = 0; drop_at = -1;
        res_conv = 16'(nxt); b_in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (b_in_ready) begin
                accepted++;
                nxt++;
            end else if (drop_at < 0) begin
                drop_at = c;
            end
            step();
            res_conv = 16'(nxt);
        end
        b_in_valid = 1'b0;
        chk("bp_accepted", 64'(accepted), 64'd4);
        chk("bp_drop_cycle", 64'(drop_at), 64'd4);
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {63'd0, b_out_valid}, 64'd1);
            chk("bp_data", {56'd0, b_out_data}, 64'(i + 1));
            chk("bp_bytes", {60'd0, b_out_bytes}, 64'd1);
            step();
        end
        chk("bp_drained", {63'd0, b_out_valid}, 64'd0);

        // Reset with one word queued and two bytes packed
        out_ready = 1'b0;
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        send(5, 1'b0); send(6, 1'b0);
        step();
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_data", {32'd0, out_data}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        expect_quiet("post_rst_nostale", 5);
        send(9, 1'b1);
        wait_valid("post_rst_valid");
        chk("post_rst_data", {32'd0, out_data}, 64'h00000009);
        chk("post_rst_bytes", {60'd0, out_bytes}, 64'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_out_packer.md
CONV_OUT_PACKER -- requirements
Module: conv_out_packer

Interface
REQ-001 PACK, default 4, number of INT8 results packed per output word (1..8).
REQ-002 DEPTH, default 4, output FIFO depth in words (minimum 4, power of two).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  res_conv qualifier, driven from the adder-tree output enable.
REQ-006 in_ready  output  1  block can accept a result this cycle.
REQ-007 res_conv  input  16  signed INT16 convolution sum from the PE adder tree.
REQ-008 bias  input  16  signed bias, sampled with each accepted result.
REQ-009 shift  input  4  requantisation right-shift amount (0..15), static per layer.
REQ-010 relu_en  input  1  clamp negatives to zero when high, static per layer.
REQ-011 flush  input  1  one-cycle pulse: emit any partial word.
REQ-012 out_data  output  PACK*8  packed INT8 word; byte 0 = oldest result, in bits [7:0].
REQ-013 out_bytes  output  4  number of valid bytes in out_data (1..PACK).
REQ-014 out_valid  output  1  out_data/out_bytes valid.
REQ-015 out_ready  input  1  consumer accepts word when high with out_valid.

Function
REQ-016 Input transfer SHALL occur when in_valid and in_ready are both high; in_valid with in_ready low SHALL be ignored (no capture).
REQ-017 Stage 1 (registered): sum = res_conv + bias in 17 bits, saturated to [-32768, 32767].
REQ-018 Stage 2 (registered): if relu_en and sum<0 then 0; else arithmetic shift right by shift with round-half-up (add 1<<(shift-1) when shift>0), saturated to [-128, 127].
REQ-019 Packer SHALL place each stage-2 byte at the next byte slot; byte counter wraps 0..PACK-1.
REQ-020 When the PACK-th byte is placed, the word SHALL be pushed into the FIFO with out_bytes=PACK in the same cycle the byte is placed.
REQ-021 Latency: with FIFO empty and out_ready high, out_valid SHALL rise 3 cycles after the transfer of the PACK-th result.
REQ-022 in_ready SHALL equal (fifo_count <= DEPTH-3), guaranteeing space for every in-flight result; no result SHALL ever be dropped.
REQ-023 Flush SHALL be latched; once both pipeline stages are empty, a nonzero partial word SHALL be pushed with unused bytes zero and out_bytes = byte count, and the counter cleared.
REQ-024 Flush with an empty packer and empty pipeline SHALL push nothing; flush coincident with an accepted input SHALL include that input.
REQ-025 in_ready SHALL be low from flush latch until the partial word is pushed.
REQ-026 out_data/out_bytes SHALL be held stable while out_valid is high and out_ready low.
REQ-027 Simultaneous FIFO push and pop SHALL keep fifo_count unchanged; pop from full and push into empty both legal in the same cycle.

Reset
REQ-028 On reset low, SHALL clear pipeline valids, packer counter, flush latch, FIFO pointers/count; out_valid=0, out_data=0, out_bytes=0, in_ready=0 while reset low.
REQ-029 Reset mid-operation SHALL discard all partial and queued data; in_ready=1 the first cycle after release.

Structure
REQ-030 INT8/INT16 widths and saturation limits SHALL come from the shared def.v constants; no local literals for them.
REQ-031 The FIFO SHALL be a sub-module named out_word_fifo (parameterised width/depth, count output).

Verification
REQ-032 res_conv=100, bias=28, shift=2, relu_en=0, four transfers -> one word 0x20202020, out_bytes=4, out_valid 3 cycles after 4th transfer.
REQ-033 res_conv=32767, bias=1 -> stage-1 saturates 32767; shift=0 -> byte 0x7F; res_conv=-300,bias=0,relu_en=1 -> byte 0x00; relu_en=0 -> 0x80.
REQ-034 Rounding: res_conv=6, bias=0, shift=2 -> 2; res_conv=5 -> 1; res_conv=-6 -> -1 (0xFF).
REQ-035 out_ready held low, continuous in_valid -> in_ready drops at fifo_count=DEPTH-2; exactly DEPTH words stored, none lost after out_ready released.
REQ-036 Three results then flush -> word 0x00CCBBAA form with out_bytes=3; second flush with nothing pending -> no word.
REQ-037 Reset asserted with 2 bytes packed and 1 word queued -> out_valid=0 immediately, no stale word after release.
